// File: rtl/reg_write_arbiter_if.sv
// Bundle between the two write requesters, the arbiter and the control register block.
// The requester/register-block side uses master, the arbiter uses slave.
interface reg_write_arbiter_if;
    logic       a_valid;
    logic [2:0] a_adress;
    logic [9:0] a_value;
    logic       a_ready;
    logic       b_valid;
    logic [2:0] b_adress;
    logic [9:0] b_value;
    logic       b_ready;
    logic [2:0] adress;
    logic [9:0] value;
    logic       load;
    logic       noise_rst;
    logic       busy;

    modport master (
        output a_valid, a_adress, a_value,
        input  a_ready,
        output b_valid, b_adress, b_value,
        input  b_ready,
        input  adress, value, load, noise_rst, busy
    );

    modport slave (
        input  a_valid, a_adress, a_value,
        output a_ready,
        input  b_valid, b_adress, b_value,
        output b_ready,
        output adress, value, load, noise_rst, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Merges register writes from two requesters through per-requester FIFOs, issuing them
// round-robin as one-cycle load strobes spaced at least GAP cycles apart.
module reg_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int GAP   = 6
) (
    input logic              clk,
    input logic              rst_n,
    reg_write_arbiter_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (GAP < 3) ? 1 : $clog2(GAP - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP >= 2) ? (GAP - 2) : 0);

    typedef enum logic {
        S_IDLE,
        S_GAP
    } state_t;

    state_t        state_q, next_state;
    logic [CW-1:0] gap_cnt_q, gap_cnt_d;
    logic          last_grant_q, last_grant_d;

    logic [1:0]       push_valid;
    logic [1:0][12:0] push_data;
    logic [1:0][12:0] head;
    logic [1:0]       empty;
    logic [1:0]       full;
    logic [1:0]       ready;
    logic [1:0]       push;
    logic [1:0]       grant;

    logic [2:0]  adress_q, adress_d;
    logic [9:0]  value_q, value_d;
    logic        load_q, load_d;
    logic        noise_rst_q, noise_rst_d;
    logic [12:0] sel_entry;

    always_comb begin
        push_valid = {bus.b_valid, bus.a_valid};
        push_data  = {{bus.b_adress, bus.b_value}, {bus.a_adress, bus.a_value}};
    end

    // Index 0 is requester A, index 1 is requester B; the extra pointer bit separates full from empty.
    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [12:0] mem_q [DEPTH];
        logic [AW:0] wr_ptr_q;
        logic [AW:0] rd_ptr_q;

        assign empty[i] = (wr_ptr_q == rd_ptr_q);
        assign full[i]  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign ready[i] = rst_n && !full[i];
        assign push[i]  = push_valid[i] && ready[i];
        assign head[i]  = mem_q[rd_ptr_q[AW-1:0]];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push[i]) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= push_data[i];
                    wr_ptr_q                <= wr_ptr_q + 1'b1;
                end
                if (grant[i]) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            adress_q     <= '0;
            value_q      <= '0;
            load_q       <= 1'b0;
            noise_rst_q  <= 1'b0;
        end else begin
            state_q      <= next_state;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            adress_q     <= adress_d;
            value_q      <= value_d;
            load_q       <= load_d;
            noise_rst_q  <= noise_rst_d;
        end
    end

    // last_grant high means B was served last, so A wins the next tie.
    always_comb begin
        next_state   = state_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        grant        = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (!empty[0] && !empty[1]) begin
                    grant = last_grant_q ? 2'b01 : 2'b10;
                end else if (!empty[0]) begin
                    grant = 2'b01;
                end else if (!empty[1]) begin
                    grant = 2'b10;
                end
                if (grant != 2'b00) begin
                    last_grant_d = grant[1];
                    if (GAP > 1) begin
                        next_state = S_GAP;
                        gap_cnt_d  = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    next_state = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
                gap_cnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        sel_entry   = grant[1] ? head[1] : head[0];
        load_d      = (grant != 2'b00);
        adress_d    = load_d ? sel_entry[12:10] : adress_q;
        value_d     = load_d ? sel_entry[9:0] : value_q;
        noise_rst_d = load_d && (sel_entry[12:10] == 3'd6);
    end

    assign bus.a_ready   = ready[0];
    assign bus.b_ready   = ready[1];
    assign bus.adress    = adress_q;
    assign bus.value     = value_q;
    assign bus.load      = load_q;
    assign bus.noise_rst = noise_rst_q;
    assign bus.busy      = (state_q == S_GAP) || !empty[0] || !empty[1];

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, entries per requester FIFO (power of two, >=2).
REQ-002 Parameter GAP, default 6, minimum clk cycles between successive load pulses (>=1).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 a_valid  input  1  requester A (parallel bus decoder) write request.
REQ-006 a_adress  input  3  requester A register index.
REQ-007 a_value  input  10  requester A register data.
REQ-008 a_ready  output  1  FIFO A can accept a write.
REQ-009 b_valid  input  1  requester B (serial/playback path) write request.
REQ-010 b_adress  input  3  requester B register index.
REQ-011 b_value  input  10  requester B register data.
REQ-012 b_ready  output  1  FIFO B can accept a write.
REQ-013 adress  output  3  register index to control register block, registered.
REQ-014 value  output  10  register data to control register block, registered.
REQ-015 load  output  1  one-cycle write strobe to control register block, registered.
REQ-016 noise_rst  output  1  one-cycle noise LFSR reset strobe, registered.
REQ-017 busy  output  1  high while any entry is pending or a GAP interval is running.

Function
REQ-018 Each requester SHALL own a DEPTH-entry FIFO of {adress,value}; push when x_valid && x_ready at a rising edge.
REQ-019 x_ready SHALL equal !full of its FIFO (combinational); x_valid while !x_ready is ignored, with no state change.
REQ-020 Pop and push on the same FIFO in the same cycle SHALL both take effect; count unchanged.
REQ-021 Per-requester write order SHALL be preserved at the output.
REQ-022 Scheduler states: IDLE, GAP.
REQ-023 IDLE, both FIFOs empty: stay IDLE, load=0, noise_rst=0.
REQ-024 IDLE, exactly one FIFO non-empty: grant it.
REQ-025 IDLE, both non-empty: grant the requester not granted last (round-robin, last_grant register).
REQ-026 On grant at edge k: register head into adress/value, set load=1, pop head, update last_grant, go to GAP.
REQ-027 noise_rst SHALL be 1 in exactly the cycles where load=1 and the issued adress==3'd6; else 0.
REQ-028 load and noise_rst SHALL be high for exactly one cycle per issued entry.
REQ-029 GAP: count GAP-1 cycles with load=0, then return to IDLE; with GAP=1 the next grant happens at edge k+1 (back-to-back loads).
REQ-030 Consecutive load pulses SHALL therefore be separated by >=GAP cycles from rising edge to rising edge.
REQ-031 adress/value SHALL hold the last issued entry while load=0.
REQ-032 Latency: write accepted at edge k into an empty FIFO, scheduler IDLE, no competitor -> load high in the cycle after edge k+1.
REQ-033 Entries arriving during GAP SHALL wait; no entry is dropped while ready was high at push.
REQ-034 busy = (state==GAP) || FIFO A non-empty || FIFO B non-empty.
REQ-035 FIFO pointers SHALL wrap modulo DEPTH; full/empty derived from an extra pointer bit or counter, correct at DEPTH entries.

Reset
REQ-036 While rst_n=0 at an edge: both FIFOs empty, pointers 0, state IDLE, GAP counter 0, last_grant=B (A wins first tie), adress=0, value=0, load=0, noise_rst=0.
REQ-037 a_ready and b_ready SHALL be 0 during cycles where rst_n=0.
REQ-038 Reset mid-operation SHALL discard all pending entries and any running GAP interval; no load in the cycle following the reset edge.

Verification
REQ-039 GAP=6: single A write {3'd0,10'h155} -> one load cycle with adress=0, value=10'h155, noise_rst=0, latency per REQ-032, busy falls 5 cycles after load.
REQ-040 A and B each push 3 entries same cycles -> loads alternate A0,B0,A1,B1,A2,B2, spaced exactly 6 cycles.
REQ-041 B write {3'd6,10'h004} -> load and noise_rst both high same single cycle, value=10'h004.
REQ-042 Push DEPTH+1 entries to A while scheduler blocked in GAP -> a_ready low after DEPTH pushes, extra push ignored, exactly DEPTH loads emitted in order.
REQ-043 GAP=1, 4 A entries queued -> 4 loads on 4 consecutive cycles.
REQ-044 Assert rst_n=0 with 3 entries pending mid-GAP -> no further loads, outputs zero, busy=0 after release.
